// File: rtl/pdm_pkg.sv
// Shared types and helpers for the PDM microphone front end.
package pdm_pkg;

  typedef enum logic [1:0] {
    PDM_IDLE   = 2'd0,
    PDM_WARMUP = 2'd1,
    PDM_RUN    = 2'd2
  } pdm_state_e;

  typedef enum logic {
    PDM_CHAN_L = 1'b0,
    PDM_CHAN_R = 1'b1
  } pdm_chan_e;

  localparam int PDM_LEVEL_W = 32;

  // +2^shift for a captured 1, -2^shift for a captured 0 (two's complement).
  function automatic logic signed [PDM_LEVEL_W-1:0] pdm_level(input logic bit_val, input int shift);
    logic signed [PDM_LEVEL_W-1:0] mag;
    mag = PDM_LEVEL_W'(1) << shift;
    return bit_val ? mag : -mag;
  endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// Microphone clock divider: period counter, registered pdm_clk and the two
// capture ticks (last cycle of the low phase / last cycle of the high phase).
module pdm_clk_gen
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cnt_en,   // current state counts (not IDLE)
  input  logic clear,    // next state is IDLE: park counter and pdm_clk
  output logic pdm_clk,
  output logic tick_r,
  output logic tick_f,
  output logic wrap
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             pdm_clk_q, pdm_clk_d;

  // Next count; pdm_clk is derived from the next count so it lines up with div_cnt.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    div_cnt_d = '0;
    if (!clear && cnt_en) begin
      div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
    end
    pdm_clk_d = !clear && (div_cnt_d <= HALF_LAST);
  end

  // Counter and clock registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    if (rst) begin
      div_cnt_q <= '0;
      pdm_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pdm_clk_q <= pdm_clk_d;
    end
  end

  assign pdm_clk = pdm_clk_q;
  assign tick_r  = cnt_en && (div_cnt_q == LAST);
  assign tick_f  = cnt_en && (div_cnt_q == HALF_LAST);
  assign wrap    = tick_r;

endmodule

// File: rtl/pdm_frontend.sv
// PDM microphone front end: clocks the mic, synchronises its data, discards
// the warm-up interval and emits +/-2^SCALE_SHIFT samples with a valid strobe.
// Define PDM_STEREO_EN to capture on both pdm_clk edges (two channels).
module pdm_frontend
  import pdm_pkg::*;
#(
  parameter int CLK_DIV       = 16,
  parameter int OUT_WIDTH     = 16,
  parameter int WARMUP_CYCLES = 4096,
  parameter int SCALE_SHIFT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 channel_sel,
  input  logic                 pdm_data,
  output logic                 pdm_clk,
  output logic                 ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_sample,
  output logic                 out_chan
);

  localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);

  pdm_state_e           state_q, state_d;
  logic [WARM_W-1:0]    warm_cnt_q, warm_cnt_d;
  logic                 sync1_q, sync2_q;
  logic                 ready_q, ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_sample_q, out_sample_d;
  pdm_chan_e            out_chan_q, out_chan_d;
  logic                 tick_r, tick_f, wrap;
  logic                 cap_tick;
  pdm_chan_e            cap_chan;

  pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .cnt_en  (state_q != PDM_IDLE),
    .clear   (state_d == PDM_IDLE),
    .pdm_clk (pdm_clk),
    .tick_r  (tick_r),
    .tick_f  (tick_f),
    .wrap    (wrap)
  );

`ifdef PDM_STEREO_EN
  logic unused_channel_sel;
  assign unused_channel_sel = channel_sel;
  assign cap_tick = tick_r | tick_f;
  assign cap_chan = tick_f ? PDM_CHAN_R : PDM_CHAN_L;
`else
  pdm_chan_e chan_q, chan_d;

  // Channel select is sampled only at period boundaries so a period is never split.
  always_comb begin
    chan_d = chan_q;
    if ((state_q == PDM_IDLE && enable) || wrap) chan_d = pdm_chan_e'(channel_sel);
  end

  // Latched channel select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chan_q <= PDM_CHAN_L;
    else     chan_q <= chan_d;
  end

  assign cap_tick = (chan_q == PDM_CHAN_R) ? tick_f : tick_r;
  assign cap_chan = chan_q;
`endif

  // State transitions and warm-up period counting.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    case (state_q)
      PDM_IDLE: begin
        warm_cnt_d = '0;
        if (enable) state_d = (WARMUP_CYCLES == 0) ? PDM_RUN : PDM_WARMUP;
      end
      PDM_WARMUP: begin
        if (wrap) begin
          if (warm_cnt_q == WARM_LAST) state_d = PDM_RUN;
          else                         warm_cnt_d = warm_cnt_q + 1'b1;
        end
      end
      PDM_RUN: ;
      default: state_d = PDM_IDLE;
    endcase
    if (!enable) state_d = PDM_IDLE;
  end

  // Output sample generation; a tick coinciding with enable falling is dropped.
  always_comb begin
    ready_d      = (state_d == PDM_RUN);
    out_valid_d  = (state_q == PDM_RUN) && enable && cap_tick;
    out_sample_d = out_sample_q;
    out_chan_d   = out_chan_q;
    if (out_valid_d) begin
      out_sample_d = OUT_WIDTH'(pdm_level(sync2_q, SCALE_SHIFT));
      out_chan_d   = cap_chan;
    end
  end

  // Synchroniser, FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      state_q      <= PDM_IDLE;
      warm_cnt_q   <= '0;
      ready_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      out_chan_q   <= PDM_CHAN_L;
    end else begin
      sync1_q      <= pdm_data;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      warm_cnt_q   <= warm_cnt_d;
      ready_q      <= ready_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      out_chan_q   <= out_chan_d;
    end
  end

  assign ready      = ready_q;
  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign out_chan   = out_chan_q;

endmodule

// File: tb/tb_pdm_frontend.sv
// Directed bench for pdm_frontend (CLK_DIV=8, WARMUP_CYCLES=4). A second
// instance with SCALE_SHIFT=4 shares all inputs. Build with PDM_STEREO_EN
// defined to run the stereo sequence instead of the mono one.
module tb_pdm_frontend;

  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          channel_sel = 1'b0;
  logic          pdm_data;
  logic          pdm_clk, ready, out_valid, out_chan;
  logic [OW-1:0] out_sample;
  logic          pdm_clk4, ready4, out_valid4, out_chan4;
  logic [OW-1:0] out_sample4;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  always #5 clk = ~clk;

  pdm_frontend #(.CLK_DIV(8), .OUT_WIDTH(OW), .WARMUP_CYCLES(4), .SCALE_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .channel_sel(channel_sel), .pdm_data(pdm_data),
    .pdm_clk(pdm_clk), .ready(ready), .out_valid(out_valid), .out_sample(out_sample), .out_chan(out_chan)
  );

  pdm_frontend #(.CLK_DIV(8), .OUT_WIDTH(OW), .WARMUP_CYCLES(4), .SCALE_SHIFT(4)) dut_s4 (
    .clk(clk), .rst(rst), .enable(enable), .channel_sel(channel_sel), .pdm_data(pdm_data),
    .pdm_clk(pdm_clk4), .ready(ready4), .out_valid(out_valid4), .out_sample(out_sample4), .out_chan(out_chan4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts edges until ready; checks the 50% pdm_clk pattern and silence meanwhile.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
      check("warm_pdm_clk", pdm_clk, 32'(((cnt - 1) % 8) < 4));
      check("warm_no_valid", out_valid, 0);
    end while (!ready && cnt < 200);
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!out_valid && cnt < 64);
  endtask

`ifdef PDM_STEREO_EN
  // Mic model: data 1 during pdm_clk low phase, 0 during high phase.
  always @(negedge clk) pdm_data = ~pdm_clk;

  initial begin
    #2;
    check("rst_pdm_clk", pdm_clk, 0);
    check("rst_valid", out_valid, 0);
    check("rst_sample", out_sample, 0);
    #12 rst = 1'b0;
    step(2);
    enable = 1'b1;
    wait_ready(n);
    check("st_ready_delay", n, 33);
    for (int i = 0; i < 3; i++) begin
      wait_valid(n);
      check("st_gap_f", n, 4);
      check("st_sample_f", out_sample, 16'hFFFF);
      check("st_sample4_f", out_sample4, 16'hFFF0);
      check("st_chan_f", out_chan, 1);
      wait_valid(n);
      check("st_gap_r", n, 4);
      check("st_sample_r", out_sample, 16'h0001);
      check("st_sample4_r", out_sample4, 16'h0010);
      check("st_chan_r", out_chan, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
`else
  initial begin
    pdm_data = 1'b0;
    #2;
    check("rst_pdm_clk", pdm_clk, 0);
    check("rst_ready", ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_sample", out_sample, 0);
    check("rst_chan", out_chan, 0);
    #12 rst = 1'b0;
    step(2);
    check("idle_pdm_clk", pdm_clk, 0);
    check("idle_ready", ready, 0);

    // Start-up: 4 discarded periods, then one sample per 8 clk.
    pdm_data = 1'b1;
    step(3);
    enable = 1'b1;
    wait_ready(n);
    check("ready_delay", n, 33);
    wait_valid(n);
    check("first_valid_gap", n, 8);
    check("first_sample", out_sample, 16'h0001);
    check("first_sample_s4", out_sample4, 16'h0010);
    check("first_chan", out_chan, 0);
    wait_valid(n);
    check("valid_period", n, 8);

    // Alternating data, one change per period.
    for (int i = 0; i < 4; i++) begin
      pdm_data = ~pdm_data;
      wait_valid(n);
      check("alt_gap", n, 8);
      check("alt_sample", out_sample, pdm_data ? 16'h0001 : 16'hFFFF);
      check("alt_sample_s4", out_sample4, pdm_data ? 16'h0010 : 16'hFFF0);
    end

    // Pin-to-valid latency of 3 clk: latest change that still lands, then one that misses.
    step(5);
    pdm_data = 1'b0;
    wait_valid(n);
    check("lat_gap_hit", n, 3);
    check("lat_sample_hit", out_sample, 16'hFFFF);
    step(6);
    pdm_data = 1'b1;
    wait_valid(n);
    check("lat_gap_miss", n, 2);
    check("lat_sample_miss", out_sample, 16'hFFFF);
    wait_valid(n);
    check("lat_gap_next", n, 8);
    check("lat_sample_next", out_sample, 16'h0001);

    // channel_sel change mid-period takes effect after the next wrap.
    step(2);
    channel_sel = 1'b1;
    wait_valid(n);
    check("sel_gap_old", n, 6);
    check("sel_chan_old", out_chan, 0);
    wait_valid(n);
    check("sel_gap_new", n, 4);
    check("sel_chan_new", out_chan, 1);
    check("sel_sample_new", out_sample, 16'h0001);
    check("sel_pdm_clk_low", pdm_clk, 0);
    wait_valid(n);
    check("sel_gap_steady", n, 8);

    // Disable on the cycle of the active tick: no sample, immediate park.
    step(7);
    enable = 1'b0;
    step(1);
    check("dis_valid", out_valid, 0);
    check("dis_pdm_clk", pdm_clk, 0);
    check("dis_ready", ready, 0);
    check("dis_sample_held", out_sample, 16'h0001);
    step(3);
    check("dis_pdm_clk_idle", pdm_clk, 0);
    check("dis_valid_idle", out_valid, 0);

    // Re-enable restarts the full warm-up.
    channel_sel = 1'b0;
    enable = 1'b1;
    wait_ready(n);
    check("reen_ready_delay", n, 33);
    wait_valid(n);
    check("reen_valid_gap", n, 8);
    check("reen_chan", out_chan, 0);

    // Asynchronous reset between edges while running.
    check("pre_rst_pdm_clk", pdm_clk, 1);
    check("pre_rst_ready", ready, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_pdm_clk", pdm_clk, 0);
    check("arst_ready", ready, 0);
    check("arst_valid", out_valid, 0);
    check("arst_sample", out_sample, 0);
    @(negedge clk);
    rst = 1'b0;
    step(2);
    check("post_rst_ready", ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
`endif

endmodule
